// File: rtl/key_scan.sv
// key_scan: 4x4 matrix keypad scanner with debounced press/release detection.
//
// A free-running divider produces a one-clk scan tick every SCAN_DIV clocks.
// On each tick the scanner steps the active-low column drive and samples the
// synchronized row lines. A press is accepted after DEBOUNCE consecutive ticks
// with the captured row low. A release is accepted after DEBOUNCE consecutive
// ticks with that row high.
//
// Parameters
//   SCAN_DIV     clk cycles per scan tick (2..2^20)
//   DEBOUNCE     consecutive identical tick samples to accept press/release (1..15)
//   REPEAT_TICKS ticks between auto-repeat events (auto-repeat builds only)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, one-hot active-low
//   binary[3:0] code of the accepted key (row*4 + column)
//   key_press  high while the accepted key is held
//
// Build option
//   KEY_SCAN_REPEAT_EN  when defined, a held key drops key_press for one tick
//                       period every REPEAT_TICKS ticks to generate repeat events.
module key_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] binary,
    output logic       key_press
);
    localparam int               DIV_W    = 20;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       r_q, r_d;
    logic [1:0]       c_q, c_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       binary_q, binary_d;
    logic             key_press_q, key_press_d;

    logic             tick;
    logic             any_low;
    logic             cap_high;
    logic [3:0]       cnt_inc;
    logic             cnt_done;

`ifdef KEY_SCAN_REPEAT_EN
    localparam int              REP_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`else
    // REPEAT_TICKS only matters when auto-repeat is built in.
    logic repeat_unused;
    assign repeat_unused = (REPEAT_TICKS > 0);
`endif

    // Next column in the 1110 -> 1101 -> 1011 -> 0111 rotation.
    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    // Lowest-numbered low row wins when several rows are low together.
    function automatic logic [1:0] first_low(input logic [3:0] v);
        if (!v[0])      return 2'd0;
        else if (!v[1]) return 2'd1;
        else if (!v[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] v);
        case (v)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign tick     = (div_q == DIV_LAST);
    assign div_d    = tick ? '0 : div_q + 1'b1;
    assign any_low  = (row_sync_q != 4'hF);
    assign cap_high = row_sync_q[r_q];
    assign cnt_inc  = cnt_q + 4'd1;
    assign cnt_done = (cnt_inc == DEB_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_SCAN;
        else        state_q <= state_d;
    end

    // Next-state logic: every transition is gated by the scan tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                ST_SCAN:
                    if (any_low) state_d = (DEBOUNCE == 1) ? ST_HELD : ST_DEBOUNCE;
                ST_DEBOUNCE:
                    if (cap_high)      state_d = ST_SCAN;
                    else if (cnt_done) state_d = ST_HELD;
                ST_HELD:
                    if (cap_high) state_d = (DEBOUNCE == 1) ? ST_SCAN : ST_RELEASE;
                ST_RELEASE:
                    if (!cap_high)     state_d = ST_HELD;
                    else if (cnt_done) state_d = ST_SCAN;
                default: state_d = ST_SCAN;
            endcase
        end
    end

    // Output / datapath logic. cnt_q serves as the press count in DEBOUNCE
    // and as the release count in RELEASE; it is cleared on every exit.
    always_comb begin
        col_d       = col_q;
        r_d         = r_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        binary_d    = binary_q;
        key_press_d = key_press_q;
`ifdef KEY_SCAN_REPEAT_EN
        rep_d       = (state_q == ST_HELD) ? rep_q : '0;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (!any_low) begin
                        col_d = rotl(col_q);
                    end else begin
                        r_d   = first_low(row_sync_q);
                        c_d   = col_index(col_q);
                        cnt_d = 4'd1;
                        if (DEBOUNCE == 1) begin
                            binary_d    = {first_low(row_sync_q), col_index(col_q)};
                            key_press_d = 1'b1;
                            cnt_d       = 4'd0;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (cap_high) begin
                        cnt_d = 4'd0;
                        col_d = rotl(col_q);
                    end else if (cnt_done) begin
                        binary_d    = {r_q, c_q};
                        key_press_d = 1'b1;
                        cnt_d       = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HELD: begin
`ifdef KEY_SCAN_REPEAT_EN
                    // Close the one-tick repeat gap, then count toward the next one.
                    if (!key_press_q) key_press_d = 1'b1;
                    if (!cap_high) begin
                        if (rep_q == REP_LAST) begin
                            rep_d       = '0;
                            key_press_d = 1'b0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
`endif
                    if (cap_high) begin
                        if (DEBOUNCE == 1) begin
                            key_press_d = 1'b0;
                            col_d       = rotl(col_q);
                            cnt_d       = 4'd0;
                        end else begin
                            cnt_d = 4'd1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!cap_high) begin
                        cnt_d = 4'd0;
                    end else if (cnt_done) begin
                        key_press_d = 1'b0;
                        col_d       = rotl(col_q);
                        cnt_d       = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers, including the 2-flop row synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_q       <= 4'b1110;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            cnt_q       <= 4'd0;
            binary_q    <= 4'd0;
            key_press_q <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            col_q       <= col_d;
            r_q         <= r_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            binary_q    <= binary_d;
            key_press_q <= key_press_d;
`ifdef KEY_SCAN_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col       = col_q;
    assign binary    = binary_q;
    assign key_press = key_press_q;

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, meaning clk cycles per scan tick (legal range 2..2^20).
REQ-002 Parameter DEBOUNCE, default 4, meaning consecutive identical scan-tick samples needed to accept a press or a release (legal range 1..15).
REQ-003 Parameter REPEAT_TICKS, default 100, meaning scan ticks between auto-repeat events (used only under KEY_SCAN_REPEAT_EN).
REQ-004 Port clk, input, 1, meaning the single system clock; all logic rising-edge.
REQ-005 Port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 Port row, input, 4, meaning keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-007 Port col, output, 4, meaning keypad column drive, one-hot active-low.
REQ-008 Port binary, output, 4, meaning code of the accepted key.
REQ-009 Port key_press, output, 1, meaning high while the accepted key is held; its falling edge marks the key event for the downstream digit recorder.

Function
REQ-010 row SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-011 Divider counter SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be high for one clk cycle at count SCAN_DIV-1.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE; all state changes occur only on tick cycles.
REQ-013 SCAN: col SHALL rotate 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step per tick, when the synchronized row is 1111.
REQ-014 SCAN with any row bit low on a tick: col SHALL freeze, row index r (lowest-numbered low bit wins) and column index c SHALL be captured, debounce count SHALL be 1, next state DEBOUNCE.
REQ-015 DEBOUNCE: a tick with the captured row bit low SHALL increment count; when count reaches DEBOUNCE, binary SHALL load r*4+c, key_press SHALL rise in that same cycle, next state HELD.
REQ-016 DEBOUNCE: a tick with the captured row bit high SHALL clear the count, leave binary and key_press unchanged, and return to SCAN with col advanced one step.
REQ-017 With DEBOUNCE=1, the press SHALL be accepted on the first tick detecting it (SCAN goes directly to HELD).
REQ-018 HELD: a tick with the captured row bit high SHALL set release count to 1 and move to RELEASE; other keys pressed meanwhile SHALL be ignored.
REQ-019 RELEASE: a high tick SHALL increment the release count, and a low tick SHALL clear it and return to HELD; on reaching DEBOUNCE, key_press SHALL fall, col SHALL advance one step, and the next state is SCAN.
REQ-020 binary SHALL change only in the cycle key_press rises and SHALL hold its value through and after key_press falls.
REQ-021 key_press SHALL be registered and glitch-free; there SHALL be at most one rising edge per accepted press (without KEY_SCAN_REPEAT_EN).

Reset
REQ-022 While rst_n is low: col=1110, binary=0000, key_press=0, state SCAN, divider, debounce and repeat counters 0, and synchronizer flops 1111.
REQ-023 Reset asserted mid-press SHALL drop key_press to 0 immediately without any other output event; after release of reset, a still-held key SHALL be re-detected as a new press.

Configuration
REQ-024 Macro KEY_SCAN_REPEAT_EN defined: in HELD, after every REPEAT_TICKS ticks held, key_press SHALL go low for exactly one tick period and then return high with binary unchanged, giving one extra downstream event per repeat.
REQ-025 Without KEY_SCAN_REPEAT_EN: no repeat counter SHALL exist, and key_press SHALL stay high for the whole HELD and RELEASE duration.

Verification
REQ-026 SCAN_DIV=4, DEBOUNCE=2; with no key pressed, col SHALL cycle 1110,1101,1011,0111 with each value lasting 4 clks.
REQ-027 Hold row[2] low while col=1011 (c=2) for 10 ticks: binary SHALL become 1010, and key_press SHALL rise 2 ticks after first detection and fall 2 ticks after release.
REQ-028 A single-tick low pulse on row[0]: key_press SHALL stay 0, binary SHALL stay at its previous value, and scanning SHALL resume.
REQ-029 Rows 1 and 3 low together on col=1110: binary SHALL become 0100 (row 1 wins).
REQ-030 Release bounce high-low-high during RELEASE: key_press SHALL remain 1 until DEBOUNCE consecutive high ticks.
REQ-031 rst_n pulsed low while in HELD: key_press SHALL be 0 within the same cycle, and col SHALL be 1110 and binary 0000.
